// File: rtl/rvv_pkg.sv
// Shared types and default widths for the vector instruction front end.
package rvv_pkg;

  localparam int unsigned DEF_INSN_WIDTH     = 32;
  localparam int unsigned DEF_VEX_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DEF_INSN_WIDTH-1:0]     insn;
    logic [DEF_VEX_DATA_WIDTH-1:0] op1;
    logic [DEF_VEX_DATA_WIDTH-1:0] op2;
  } insn_entry_t;

endpackage

// File: rtl/rvv_sync_fifo.sv
// Single-clock show-ahead FIFO: storage, wrapping pointers and fill count.
module rvv_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvv_insn_queue_front.sv
// DEPTH-entry instruction queue between the VexRiscv issue port and rvv_proc_main,
// with optional empty-queue bypass, flush gating and a sticky overflow flag.
module rvv_insn_queue_front
  import rvv_pkg::*;
#(
  parameter int unsigned INSN_WIDTH     = DEF_INSN_WIDTH,
  parameter int unsigned VEX_DATA_WIDTH = DEF_VEX_DATA_WIDTH,
  parameter int unsigned DEPTH          = 4,
  parameter bit          BYPASS         = 1'b1,
  parameter int unsigned CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INSN_WIDTH-1:0]     insn_in,
  input  logic                      insn_valid,
  input  logic [VEX_DATA_WIDTH-1:0] vexrv_data_in_1,
  input  logic [VEX_DATA_WIDTH-1:0] vexrv_data_in_2,
  output logic                      insn_ready_out,
  input  logic                      flush,
  input  logic                      core_rdy,
  output logic [INSN_WIDTH-1:0]     insn_out,
  output logic                      insn_out_valid,
  output logic [VEX_DATA_WIDTH-1:0] vexrv_data_out_1,
  output logic [VEX_DATA_WIDTH-1:0] vexrv_data_out_2,
  output logic [CNT_W-1:0]          fill_level,
  output logic                      overflow_err,
  input  logic                      err_clr
);

  typedef struct packed {
    logic [INSN_WIDTH-1:0]     insn;
    logic [VEX_DATA_WIDTH-1:0] op1;
    logic [VEX_DATA_WIDTH-1:0] op2;
  } entry_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t           wr_entry;
  entry_t           rd_entry;
  logic [CNT_W-1:0] count;
  logic             bypass_act;
  logic             push;
  logic             pop;
  logic             fifo_wr;
  logic             fifo_rd;

  assign wr_entry = '{insn: insn_in, op1: vexrv_data_in_1, op2: vexrv_data_in_2};

  always_comb begin
    bypass_act     = BYPASS && (count == '0) && insn_valid && !flush;
    insn_out_valid = !flush && ((count != '0) || bypass_act);
    pop            = insn_out_valid && core_rdy;
    insn_ready_out = !flush && ((count != FULL_CNT) || pop);
    push           = insn_valid && insn_ready_out;
    // A bypassed entry taken by the core in the same cycle never touches storage.
    fifo_wr        = push && !(bypass_act && core_rdy);
    fifo_rd        = pop && !bypass_act;
    insn_out         = bypass_act ? insn_in         : rd_entry.insn;
    vexrv_data_out_1 = bypass_act ? vexrv_data_in_1 : rd_entry.op1;
    vexrv_data_out_2 = bypass_act ? vexrv_data_in_2 : rd_entry.op2;
  end

  rvv_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (fifo_rd),
    .rd_data (rd_entry),
    .count   (count)
  );

  assign fill_level = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow_err <= 1'b0;
    else if (insn_valid && !insn_ready_out && !flush)
      overflow_err <= 1'b1;
    else if (err_clr)
      overflow_err <= 1'b0;
  end

endmodule

// File: tb/tb_rvv_insn_queue_front.sv
// Randomized and directed check of rvv_insn_queue_front (BYPASS=0 and BYPASS=1 side by side)
// against a queue-based reference model.
module tb_rvv_insn_queue_front;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] insn_in = '0, d1 = '0, d2 = '0;
  logic        insn_valid = 1'b0, flush = 1'b0, core_rdy = 1'b0, err_clr = 1'b0;

  logic [31:0] o_insn [2];
  logic [31:0] o_d1   [2];
  logic [31:0] o_d2   [2];
  logic        o_valid[2];
  logic        o_ready[2];
  logic        o_ovf  [2];
  logic [2:0]  o_fill [2];

  logic [95:0] mq [2][$];
  bit          movf [2];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  rvv_insn_queue_front #(.DEPTH(DEPTH), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .insn_in(insn_in), .insn_valid(insn_valid),
    .vexrv_data_in_1(d1), .vexrv_data_in_2(d2), .insn_ready_out(o_ready[0]),
    .flush(flush), .core_rdy(core_rdy), .insn_out(o_insn[0]), .insn_out_valid(o_valid[0]),
    .vexrv_data_out_1(o_d1[0]), .vexrv_data_out_2(o_d2[0]), .fill_level(o_fill[0]),
    .overflow_err(o_ovf[0]), .err_clr(err_clr));

  rvv_insn_queue_front #(.DEPTH(DEPTH), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .insn_in(insn_in), .insn_valid(insn_valid),
    .vexrv_data_in_1(d1), .vexrv_data_in_2(d2), .insn_ready_out(o_ready[1]),
    .flush(flush), .core_rdy(core_rdy), .insn_out(o_insn[1]), .insn_out_valid(o_valid[1]),
    .vexrv_data_out_1(o_d1[1]), .vexrv_data_out_2(o_d2[1]), .fill_level(o_fill[1]),
    .overflow_err(o_ovf[1]), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), 64'(o_valid[k]), 64'd0);
      chk($sformatf("rst_ready%0d", k), 64'(o_ready[k]), 64'd1);
      chk($sformatf("rst_fill%0d", k),  64'(o_fill[k]),  64'd0);
      chk($sformatf("rst_ovf%0d", k),   64'(o_ovf[k]),   64'd0);
      chk($sformatf("rst_insn%0d", k),  64'(o_insn[k]),  64'd0);
      chk($sformatf("rst_op1_%0d", k),  64'(o_d1[k]),    64'd0);
      chk($sformatf("rst_op2_%0d", k),  64'(o_d2[k]),    64'd0);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must drop before the next clock.
  task automatic do_reset();
    @(negedge clk);
    insn_valid = 1'b0; flush = 1'b0; err_clr = 1'b0; core_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit v, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input bit r, input bit f, input bit c);
    int n;
    bit byp, ev, pop, rdy, push;
    logic [95:0] head;
    @(negedge clk);
    insn_valid = v; insn_in = i; d1 = a; d2 = b; core_rdy = r; flush = f; err_clr = c;
    #1;
    for (int k = 0; k < 2; k++) begin
      n    = mq[k].size();
      byp  = (k == 1) && (n == 0) && v && !f;
      ev   = !f && ((n != 0) || byp);
      head = byp ? {i, a, b} : ((n != 0) ? mq[k][0] : 96'd0);
      chk($sformatf("valid%0d", k), 64'(o_valid[k]), 64'(ev));
      if (ev) begin
        chk($sformatf("insn%0d", k), 64'(o_insn[k]), 64'(head[95:64]));
        chk($sformatf("op1_%0d", k), 64'(o_d1[k]),   64'(head[63:32]));
        chk($sformatf("op2_%0d", k), 64'(o_d2[k]),   64'(head[31:0]));
      end
      pop  = ev && r;
      rdy  = !f && ((n < DEPTH) || pop);
      chk($sformatf("ready%0d", k), 64'(o_ready[k]), 64'(rdy));
      push = v && rdy;
      if (f) mq[k].delete();
      else begin
        if (pop && !byp) void'(mq[k].pop_front());
        if (push && !(byp && pop)) mq[k].push_back({i, a, b});
      end
      if (v && !rdy && !f) movf[k] = 1'b1;
      else if (c)          movf[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("fill%0d", k), 64'(o_fill[k]), 64'(mq[k].size()));
      chk($sformatf("ovf%0d", k),  64'(o_ovf[k]),  64'(movf[k]));
    end
  endtask

  initial begin
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single push while the core stalls, then drain.
    cycle(1, 32'h0000_0057, 32'h1000, 32'h4, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    // Empty-queue bypass with the core ready.
    cycle(1, 32'h0200_7007, 32'h11, 32'h22, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);

    // Fill to DEPTH, overflow on the fifth, clear, then push+pop on full across wrap.
    for (int j = 0; j < 5; j++) cycle(1, 32'hA0 + j, 32'h100 + j, 32'h200 + j, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 32'hF0, 32'h1F0, 32'h2F0, 1, 0, 0);
    for (int j = 0; j < 5; j++) cycle(0, 0, 0, 0, 1, 0, 0);

    // Three entries queued, then flush together with a push.
    for (int j = 0; j < 3; j++) cycle(1, 32'hC0 + j, j, j, 0, 0, 0);
    cycle(1, 32'hDD, 32'hDD, 32'hDD, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);

    // Reset with two entries queued, then traffic restarts from slot 0.
    cycle(1, 32'h51, 1, 1, 0, 0, 0);
    cycle(1, 32'h52, 2, 2, 0, 0, 0);
    do_reset();
    cycle(1, 32'h61, 3, 3, 0, 0, 0);
    cycle(1, 32'h62, 4, 4, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);

    for (int j = 0; j < 600; j++)
      cycle(($urandom_range(0, 9) < 7), $urandom, $urandom, $urandom,
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
